// File: rtl/vga_mode_sequencer_pkg.sv
// Shared mode codes, per-cycle action encoding and wrap-around step helpers
// for the VGA mode sequencer.
package vga_mode_sequencer_pkg;

  localparam int unsigned MODE_BAR    = 1;
  localparam int unsigned MODE_CHAR   = 2;
  localparam int unsigned MODE_CUSTOM = 3;

  typedef enum logic [2:0] {
    ActNone,
    ActSel,
    ActSelErr,
    ActCancel,
    ActNext,
    ActPrev,
    ActAuto
  } mode_act_e;

  function automatic int unsigned wrap_inc(input int unsigned cur_mode,
                                           input int unsigned base,
                                           input int unsigned num);
    return (cur_mode >= base + num - 1) ? base : cur_mode + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned cur_mode,
                                           input int unsigned base,
                                           input int unsigned num);
    return (cur_mode <= base) ? base + num - 1 : cur_mode - 1;
  endfunction

endpackage

// File: rtl/vga_mode_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level counter and a
// one-cycle rising-edge pulse on the accepted level.
module vga_mode_sequencer_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_btn_raw,
  output logic o_btn_level,
  output logic o_btn_rise
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = r_sync[1] ^ r_level;
  // The new level is accepted once it has differed for DEBOUNCE_CYC cycles in a row.
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn_raw};
      r_cnt  <= (!w_diff || w_accept) ? '0 : r_cnt + CNT_W'(1);
      if (w_accept) begin
        r_level <= r_sync[1];
      end
      r_rise <= w_accept && r_sync[1];
    end
  end

  assign o_btn_level = r_level;
  assign o_btn_rise  = r_rise;

endmodule

// File: rtl/vga_mode_sequencer.sv
// Display-mode selector: prioritised direct select, next/prev buttons and an
// auto-cycle timer drive a registered mode code plus change/error pulses.
module vga_mode_sequencer
  import vga_mode_sequencer_pkg::*;
#(
  parameter int unsigned NUM_MODES      = MODE_CUSTOM - MODE_BAR + 1,
  parameter int unsigned MODE_W         = 2,
  parameter int unsigned MODE_BASE      = MODE_BAR,
  parameter int unsigned RESET_MODE     = MODE_BAR,
  parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
  parameter int unsigned AUTO_CYCLE_CYC = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_btn_next,
  input  logic              i_btn_prev,
  input  logic              i_auto_en,
  input  logic              i_sel_valid,
  input  logic [MODE_W-1:0] i_sel_mode,
  output logic [MODE_W-1:0] o_mode_out,
  output logic              o_mode_chg,
  output logic              o_sel_err
);

  localparam int unsigned      MODE_LAST = MODE_BASE + NUM_MODES - 1;
  localparam logic [MODE_W:0]  SEL_LO    = (MODE_W + 1)'(MODE_BASE);
  localparam logic [MODE_W:0]  SEL_HI    = (MODE_W + 1)'(MODE_LAST);
  localparam int unsigned      AUTO_W    = $clog2(AUTO_CYCLE_CYC + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLE_CYC - 1);

  logic [MODE_W-1:0] r_mode;
  logic              r_chg;
  logic              r_err;
  logic [AUTO_W-1:0] r_auto_cnt;

  logic              w_next_rise;
  logic              w_prev_rise;
  logic [1:0]        w_btn_level_unused;
  logic [MODE_W:0]   w_sel_ext;
  logic              w_sel_in_range;
  logic              w_auto_tick;
  logic              w_timer_clr;
  mode_act_e         w_act;
  logic [MODE_W-1:0] w_mode_nxt;

  vga_mode_sequencer_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_next (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_btn_raw  (i_btn_next),
    .o_btn_level(w_btn_level_unused[0]),
    .o_btn_rise (w_next_rise)
  );

  vga_mode_sequencer_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_prev (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_btn_raw  (i_btn_prev),
    .o_btn_level(w_btn_level_unused[1]),
    .o_btn_rise (w_prev_rise)
  );

  // Widened by one bit so the upper bound cannot overflow.
  assign w_sel_ext      = {1'b0, i_sel_mode};
  assign w_sel_in_range = (w_sel_ext >= SEL_LO) && (w_sel_ext <= SEL_HI);
  assign w_auto_tick    = i_auto_en && (r_auto_cnt == AUTO_LAST);

  always_comb begin
    w_act = ActNone;
    if (i_sel_valid) begin
      w_act = w_sel_in_range ? ActSel : ActSelErr;
    end else if (w_next_rise && w_prev_rise) begin
      w_act = ActCancel;
    end else if (w_next_rise) begin
      w_act = ActNext;
    end else if (w_prev_rise) begin
      w_act = ActPrev;
    end else if (w_auto_tick) begin
      w_act = ActAuto;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    unique case (w_act)
      ActSel:           w_mode_nxt = i_sel_mode;
      ActNext, ActAuto: w_mode_nxt = MODE_W'(wrap_inc(32'(r_mode), MODE_BASE, NUM_MODES));
      ActPrev:          w_mode_nxt = MODE_W'(wrap_dec(32'(r_mode), MODE_BASE, NUM_MODES));
      default:          ;
    endcase
  end

  // Manual actions restart the dwell so auto mode never steps right after a user choice.
  assign w_timer_clr = !i_auto_en || w_auto_tick ||
                       (w_act == ActSel) || (w_act == ActNext) || (w_act == ActPrev);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode     <= MODE_W'(RESET_MODE);
      r_chg      <= 1'b0;
      r_err      <= 1'b0;
      r_auto_cnt <= '0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_chg      <= (w_mode_nxt != r_mode);
      r_err      <= (w_act == ActSelErr);
      r_auto_cnt <= w_timer_clr ? '0 : r_auto_cnt + AUTO_W'(1);
    end
  end

  assign o_mode_out = r_mode;
  assign o_mode_chg = r_chg;
  assign o_sel_err  = r_err;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer: vector table for direct select plus
// hand sequences for debounce timing, wrap, cancel, priority, auto-cycle and reset.
module tb_vga_mode_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       i_btn_next = 1'b0;
  logic       i_btn_prev = 1'b0;
  logic       i_auto_en = 1'b0;
  logic       i_sel_valid = 1'b0;
  logic [1:0] i_sel_mode = 2'd0;
  logic [1:0] o_mode_out;
  logic       o_mode_chg;
  logic       o_sel_err;

  int total = 0;
  int bad = 0;

  vga_mode_sequencer #(
    .NUM_MODES     (3),
    .MODE_W        (2),
    .MODE_BASE     (1),
    .RESET_MODE    (1),
    .DEBOUNCE_CYC  (4),
    .AUTO_CYCLE_CYC(10)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_btn_next (i_btn_next),
    .i_btn_prev (i_btn_prev),
    .i_auto_en  (i_auto_en),
    .i_sel_valid(i_sel_valid),
    .i_sel_mode (i_sel_mode),
    .o_mode_out (o_mode_out),
    .o_mode_chg (o_mode_chg),
    .o_sel_err  (o_sel_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       sv;
    logic [1:0] sm;
    logic [1:0] em;
    logic       ec;
    logic       ee;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    i_sel_valid = 1'b1;
    i_sel_mode  = m;
    step();
    i_sel_valid = 1'b0;
  endtask

  task automatic press(input logic nx, input logic pv, output int chg_count);
    chg_count  = 0;
    i_btn_next = nx;
    i_btn_prev = pv;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_mode_chg) chg_count++;
    end
    i_btn_next = 1'b0;
    i_btn_prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_mode_chg) chg_count++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg_cnt;
    int chg_edge;

    vecs[0]  = '{1'b1, 2'd3, 2'd3, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 2'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 2'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 2'd3, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'd3, 2'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 2'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 2'd1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 2'd3, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0};

    // Reset state, during and after reset
    repeat (3) step();
    check("in_reset_mode", o_mode_out, 1);
    sys_rst_n = 1'b1;
    step();
    check("reset_mode", o_mode_out, 1);
    check("reset_chg", o_mode_chg, 0);
    check("reset_err", o_sel_err, 0);

    // Direct-select vector table
    for (int i = 0; i < 12; i++) begin
      i_sel_valid = vecs[i].sv;
      i_sel_mode  = vecs[i].sm;
      step();
      check($sformatf("vec%0d_mode", i), o_mode_out, vecs[i].em);
      check($sformatf("vec%0d_chg", i), o_mode_chg, vecs[i].ec);
      check($sformatf("vec%0d_err", i), o_sel_err, vecs[i].ee);
    end
    i_sel_valid = 1'b0;

    // Held button: one step, on the 7th edge after the first high sample
    i_btn_next = 1'b1;
    chg_cnt  = 0;
    chg_edge = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_mode_chg) begin
        chg_cnt++;
        if (chg_edge < 0) chg_edge = k;
      end
    end
    check("held_chg_count", chg_cnt, 1);
    check("held_chg_edge", chg_edge, 7);
    check("held_mode", o_mode_out, 2);
    i_btn_next = 1'b0;
    repeat (10) step();

    // 3-cycle glitch is ignored
    chg_cnt = 0;
    i_btn_next = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) i_btn_next = 1'b0;
      step();
      if (o_mode_chg) chg_cnt++;
    end
    check("glitch_chg_count", chg_cnt, 0);
    check("glitch_mode", o_mode_out, 2);

    // Wrap in both directions
    set_mode(2'd1);
    press(1'b1, 1'b0, chg_cnt);
    check("wrap_next1_mode", o_mode_out, 2);
    check("wrap_next1_chg", chg_cnt, 1);
    press(1'b1, 1'b0, chg_cnt);
    check("wrap_next2_mode", o_mode_out, 3);
    press(1'b1, 1'b0, chg_cnt);
    check("wrap_next3_mode", o_mode_out, 1);
    check("wrap_next3_chg", chg_cnt, 1);
    press(1'b0, 1'b1, chg_cnt);
    check("wrap_prev_mode", o_mode_out, 3);
    check("wrap_prev_chg", chg_cnt, 1);

    // Simultaneous next and prev cancel
    press(1'b1, 1'b1, chg_cnt);
    check("cancel_mode", o_mode_out, 3);
    check("cancel_chg", chg_cnt, 0);

    // sel_valid in the same cycle as the next pulse wins, pulse not deferred
    i_btn_next = 1'b1;
    repeat (6) step();
    i_sel_valid = 1'b1;
    i_sel_mode  = 2'd2;
    step();
    i_sel_valid = 1'b0;
    check("selprio_mode", o_mode_out, 2);
    check("selprio_chg", o_mode_chg, 1);
    step();
    check("selprio_after_mode", o_mode_out, 2);
    i_btn_next = 1'b0;
    repeat (8) step();
    check("selprio_settle_mode", o_mode_out, 2);

    // Auto-cycle every 10 edges
    set_mode(2'd1);
    i_auto_en = 1'b1;
    chg_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (o_mode_chg) chg_cnt++;
      check($sformatf("auto_mode_k%0d", k), o_mode_out, (k / 10) % 3 + 1);
    end
    check("auto_chg_count", chg_cnt, 3);

    // Manual press mid-dwell restarts the timer
    i_btn_next = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 8) i_btn_next = 1'b0;
      check($sformatf("dwell_mode_k%0d", k), o_mode_out, (k < 7) ? 1 : ((k < 17) ? 2 : 3));
    end

    // auto_en low freezes the mode
    i_auto_en = 1'b0;
    chg_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (o_mode_chg) chg_cnt++;
    end
    check("frozen_chg_count", chg_cnt, 0);
    check("frozen_mode", o_mode_out, 3);

    // Asynchronous reset mid-run discards the pending change pulse
    set_mode(2'd2);
    set_mode(2'd3);
    check("prerst_chg", o_mode_chg, 1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_mode", o_mode_out, 1);
    check("async_rst_chg", o_mode_chg, 0);
    check("async_rst_err", o_sel_err, 0);
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();
    check("post_rst_mode", o_mode_out, 1);
    check("post_rst_chg", o_mode_chg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
